inst_axi_bridge: RTL and testbench

Responder for the fetch stage's SRAM-like instruction request interface (inst_req / inst_addr / inst_addr_ok), converting each accepted request into a single-beat AXI3 read.
- Returns the instruction word to the fetch side via inst_data_ok / inst_rdata, strictly in request order.
- Sits between fetch_stage and the CPU top-level AXI crossbar port.

---
 rtl/inst_axi_bridge_pkg.sv | 32 +++
 rtl/inst_axi_bridge.sv | 114 +++++++++++
 tb/tb_inst_axi_bridge.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_bridge_pkg.sv
// Shared AXI constants, AR state encoding and the captured read-request payload
// for the instruction-side AXI bridge.
package inst_axi_bridge_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned CACHE_W = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned PERF_W  = 32;

  localparam logic [1:0]         AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]         AXI_SIZE_4B    = 3'd2;
  localparam logic [CACHE_W-1:0] AXI_CACHE_WBRA = 4'b1111;
  localparam logic [CACHE_W-1:0] AXI_CACHE_UC   = 4'b0000;
  localparam logic [1:0]         AXI_RESP_OKAY  = 2'b00;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [CACHE_W-1:0] cache;
  } ar_req_t;

  function automatic logic [CACHE_W-1:0] ar_cache_attr(input logic cached);
    return cached ? AXI_CACHE_WBRA : AXI_CACHE_UC;
  endfunction

endpackage

// File: rtl/inst_axi_bridge.sv
// Fetch-side SRAM-like request port to single-beat AXI3 read bridge.
// Responses return in request order; one AR register with back-to-back reload.
module inst_axi_bridge
  import inst_axi_bridge_pkg::*;
#(
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [ID_W-1:0] AXI_ID          = 4'd0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic                inst_cache,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_data_err,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [CACHE_W-1:0]  arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic                busy,
  output logic [PERF_W-1:0]   perfcnt_ar_stall
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  ar_state_t        state, state_nxt;
  ar_req_t          ar_q, ar_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req_hs;
  logic             ar_fire;
  logic             unused_r;

  // Single ID, strictly in-order responses: rid/rlast carry no information here.
  assign unused_r = ^{rid, rlast, rresp[0]};

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arprot  = 3'd0;
  assign rready  = 1'b1;

  assign arvalid = (state == AR_BUSY);
  assign araddr  = ar_q.addr;
  assign arcache = ar_q.cache;
  assign busy    = (cnt != '0) || arvalid;

  // A new address is taken only when the AR register is free or draining this cycle.
  assign inst_addr_ok = resetn && ((state == AR_IDLE) || arready) && (cnt < MAX_CNT);
  assign req_hs       = inst_req && inst_addr_ok;
  assign ar_fire      = arvalid && arready;

  always_comb begin
    state_nxt = state;
    ar_nxt    = ar_q;
    case (state)
      AR_IDLE: if (req_hs) state_nxt = AR_BUSY;
      AR_BUSY: if (ar_fire && !req_hs) state_nxt = AR_IDLE;
      default: state_nxt = AR_IDLE;
    endcase
    if (req_hs) begin
      ar_nxt = '{addr: inst_addr, cache: ar_cache_attr(inst_cache)};
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (req_hs && !inst_data_ok) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (!req_hs && inst_data_ok && (cnt != '0)) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= AR_IDLE;
      ar_q             <= '0;
      cnt              <= '0;
      inst_data_ok     <= 1'b0;
      inst_data_err    <= 1'b0;
      inst_rdata       <= '0;
      perfcnt_ar_stall <= '0;
    end else begin
      state        <= state_nxt;
      ar_q         <= ar_nxt;
      cnt          <= cnt_nxt;
      inst_data_ok <= rvalid;
      if (rvalid) begin
        inst_rdata    <= rdata;
        inst_data_err <= rresp[1];
      end
      if (arvalid && !arready) begin
        perfcnt_ar_stall <= perfcnt_ar_stall + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Bench for inst_axi_bridge: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level queue model.
module tb_inst_axi_bridge;
  import inst_axi_bridge_pkg::*;

  localparam int unsigned MAXO  = 2;
  localparam int unsigned NRAND = 3000;
  localparam int unsigned NVEC  = 13;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_cache;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok, inst_data_err;
  logic [31:0] inst_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, busy;
  logic [31:0] perfcnt_ar_stall;

  inst_axi_bridge #(.MAX_OUTSTANDING(MAXO), .AXI_ID(4'd0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .inst_data_err(inst_data_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .busy(busy), .perfcnt_ar_stall(perfcnt_ar_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned tcyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: pending AR queue, issued-but-unanswered queue, counters.
  typedef struct {
    logic [31:0] addr;
    logic        cache;
  } ar_ent_t;

  ar_ent_t     ar_q[$];
  logic [31:0] issued[$];
  logic [31:0] ar_log[$];
  int unsigned ar_log_cyc[$];
  int          m_cnt;
  logic        m_dok;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_perf;
  int          acc_count;
  logic        last_ok;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    ar_q.delete();
    issued.delete();
    ar_log.delete();
    ar_log_cyc.delete();
    m_cnt = 0;
    m_dok = 1'b0;
    m_rdata = 32'h0;
    m_err = 1'b0;
    m_perf = 32'h0;
    acc_count = 0;
  endtask

  task automatic check_outputs();
    chk("arvalid", 32'(arvalid), 32'(ar_q.size() != 0));
    if (ar_q.size() != 0) begin
      chk("araddr", araddr, ar_q[0].addr);
      chk("arcache", 32'(arcache), ar_q[0].cache ? 32'hF : 32'h0);
    end
    chk("inst_data_ok", 32'(inst_data_ok), 32'(m_dok));
    if (m_dok) begin
      chk("inst_rdata", inst_rdata, m_rdata);
      chk("inst_data_err", 32'(inst_data_err), 32'(m_err));
    end
    chk("busy", 32'(busy), 32'((m_cnt != 0) || (ar_q.size() != 0)));
    chk("perfcnt_ar_stall", perfcnt_ar_stall, m_perf);
  endtask

  // One clock of stimulus starting at a falling edge; the slave returns a beat only for an issued read.
  task automatic cycle(input logic req, input logic [31:0] addr, input logic cache,
                       input logic ardy, input logic want_r, input logic [1:0] resp);
    logic        beat, exp_ok, hs, fire;
    logic [31:0] bdata;
    ar_ent_t     e;
    beat  = want_r && (issued.size() != 0);
    bdata = beat ? mem_word(issued[0]) : 32'h0;
    inst_req = req; inst_addr = addr; inst_cache = cache; arready = ardy;
    rvalid = beat; rdata = bdata; rresp = beat ? resp : 2'b00; rlast = beat;
    exp_ok = (m_cnt < int'(MAXO)) && ((ar_q.size() == 0) || ardy);
    #1;
    last_ok = inst_addr_ok;
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_ok));
    hs   = req && exp_ok;
    fire = (ar_q.size() != 0) && ardy;
    @(posedge clk);
    tcyc++;
    if ((ar_q.size() != 0) && !ardy) m_perf = m_perf + 32'd1;
    m_cnt = m_cnt + (hs ? 1 : 0) - (m_dok ? 1 : 0);
    if (beat) void'(issued.pop_front());
    if (fire) begin
      e = ar_q.pop_front();
      issued.push_back(e.addr);
      ar_log.push_back(e.addr);
      ar_log_cyc.push_back(tcyc);
    end
    if (hs) begin
      e.addr = addr;
      e.cache = cache;
      ar_q.push_back(e);
      acc_count++;
    end
    m_dok = beat;
    if (beat) begin
      m_rdata = bdata;
      m_err = resp[1];
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    inst_req = 1'b1; inst_addr = 32'h40; inst_cache = 1'b1; arready = 1'b1;
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rid = 4'd0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst arvalid", 32'(arvalid), 32'h0);
    chk("rst inst_data_ok", 32'(inst_data_ok), 32'h0);
    chk("rst inst_data_err", 32'(inst_data_err), 32'h0);
    chk("rst inst_rdata", inst_rdata, 32'h0);
    chk("rst araddr", araddr, 32'h0);
    chk("rst arcache", 32'(arcache), 32'h0);
    chk("rst perfcnt", perfcnt_ar_stall, 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst inst_addr_ok", 32'(inst_addr_ok), 32'h0);
    inst_req = 1'b0;
    resetn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        cache;
    logic        ardy;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        e_ok;
    logic        e_arv;
    logic [31:0] e_araddr;
    logic [3:0]  e_arcache;
    logic        e_dok;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_busy;
    logic [31:0] e_perf;
  } vec_t;

  vec_t vt[NVEC];

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish, required completion within 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int blocked;
    int n;
    logic [31:0] want_addr;

    // Single uncached fetch, then a 5-cycle AR stall followed by a SLVERR beat.
    vt[0]  = '{1'b1, 32'h1FC0_0000, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00,
               1'b1, 1'b1, 32'h1FC0_0000, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0};
    vt[1]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00,
               1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0};
    vt[2]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3C08_BFC0, 2'b00,
               1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 32'h3C08_BFC0, 1'b0, 1'b1, 32'd0};
    vt[3]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00,
               1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h3C08_BFC0, 1'b0, 1'b0, 32'd0};
    vt[4]  = '{1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00,
               1'b1, 1'b1, 32'h0000_1000, 4'hF, 1'b0, 32'h3C08_BFC0, 1'b0, 1'b1, 32'd0};
    for (int k = 5; k <= 9; k++) begin
      vt[k] = '{1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00,
                1'b0, 1'b1, 32'h0000_1000, 4'hF, 1'b0, 32'h3C08_BFC0, 1'b0, 1'b1, 32'(k - 4)};
    end
    vt[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00,
               1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h3C08_BFC0, 1'b0, 1'b1, 32'd5};
    vt[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 2'b10,
               1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'd5};
    vt[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00,
               1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 32'd5};

    do_reset();

    for (int i = 0; i < int'(NVEC); i++) begin
      inst_req = vt[i].req; inst_addr = vt[i].addr; inst_cache = vt[i].cache;
      arready = vt[i].ardy; rvalid = vt[i].rv; rdata = vt[i].rd; rresp = vt[i].rr;
      rlast = vt[i].rv;
      #1;
      chk($sformatf("vec%0d inst_addr_ok", i), 32'(inst_addr_ok), 32'(vt[i].e_ok));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d arvalid", i), 32'(arvalid), 32'(vt[i].e_arv));
      if (vt[i].e_arv) begin
        chk($sformatf("vec%0d araddr", i), araddr, vt[i].e_araddr);
        chk($sformatf("vec%0d arcache", i), 32'(arcache), 32'(vt[i].e_arcache));
      end
      chk($sformatf("vec%0d inst_data_ok", i), 32'(inst_data_ok), 32'(vt[i].e_dok));
      chk($sformatf("vec%0d inst_rdata", i), inst_rdata, vt[i].e_rdata);
      if (vt[i].e_dok) chk($sformatf("vec%0d inst_data_err", i), 32'(inst_data_err), 32'(vt[i].e_err));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d perfcnt", i), perfcnt_ar_stall, vt[i].e_perf);
      chk($sformatf("vec%0d ar_const", i),
          32'({arid, arlen, arsize, arburst, arlock, arprot, rready}),
          32'({4'd0, 8'd0, 3'd2, 2'b01, 2'b00, 3'd0, 1'b1}));
    end

    // Asynchronous reset with two requests in flight and a response pulse showing.
    do_reset();
    cycle(1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 2'b00);
    cycle(1'b1, 32'h0000_0204, 1'b1, 1'b1, 1'b0, 2'b00);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00);
    #2;
    resetn = 1'b0;
    inst_req = 1'b0; rvalid = 1'b0;
    #1;
    chk("async arvalid", 32'(arvalid), 32'h0);
    chk("async inst_data_ok", 32'(inst_data_ok), 32'h0);
    chk("async busy", 32'(busy), 32'h0);
    chk("async perfcnt", perfcnt_ar_stall, 32'h0);
    chk("async inst_addr_ok", 32'(inst_addr_ok), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    // Outstanding limit: third request held off until the first response retires.
    cycle(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 2'b00);
    cycle(1'b1, 32'h0000_0104, 1'b0, 1'b1, 1'b0, 2'b00);
    cycle(1'b1, 32'h0000_0108, 1'b0, 1'b1, 1'b0, 2'b00);
    chk("limit third_req_refused", 32'(last_ok), 32'h0);
    blocked = 0;
    n = 0;
    do begin
      cycle(1'b1, 32'h0000_0108, 1'b0, 1'b1, 1'b1, 2'b00);
      if (!last_ok) blocked++;
      n++;
    end while (!last_ok && n < 20);
    chk("limit third_req_wait", 32'(blocked), 32'd2);
    repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00);

    // Back-to-back issue: each address held until accepted.
    ar_log.delete();
    ar_log_cyc.delete();
    for (int a = 0; a < 3; a++) begin
      want_addr = 32'(a * 4);
      n = 0;
      do begin
        cycle(1'b1, want_addr, 1'b1, 1'b1, 1'b1, 2'b00);
        n++;
      end while (!last_ok && n < 20);
    end
    repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00);
    chk("b2b ar_count", 32'(ar_log.size()), 32'd3);
    if (ar_log.size() >= 3) begin
      chk("b2b addr0", ar_log[0], 32'h0);
      chk("b2b addr1", ar_log[1], 32'h4);
      chk("b2b addr2", ar_log[2], 32'h8);
      chk("b2b consecutive", ar_log_cyc[1] - ar_log_cyc[0], 32'd1);
    end

    // Randomized traffic against the queue model.
    for (int r = 0; r < int'(NRAND); r++) begin
      cycle($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)));
    end
    repeat (20) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00);
    chk("final busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
